// File: rtl/packet_tx_source.sv
// Software-programmed AXI-Stream packet transmitter.
// The host loads 16-bit words into a local buffer over Avalon-MM, sets DEST and LEN,
// and then writes start. The packet is streamed with tdest, honouring tready.
//
// Ports:
//   clk, reset_n         single rising-edge clock, async active-low reset
//   writedata/write/chipselect/address/read/readdata
//                        Avalon-MM slave (8-bit, registered readdata)
//   tx_tdata/tx_tvalid/tx_tlast/tx_tdest/tx_tready
//                        AXI-Stream master toward a switch ingress port
//   irq                  level interrupt, done & irq_en
//
// Register map:
//   0x00 CTRL     W: b0 start, b1 abort, b2 irq_en, b3 clear done/aborted
//                 R: {4'b0, irq_en, aborted, done, busy}
//   0x01 DEST     R/W
//   0x02 LEN      R/W, packet length in words
//   0x03 DATA_LO  W: stage low byte
//   0x04 DATA_HI  W: write {hi, lo} to buf[wptr], wptr++
//   0x05 WPTR     R: wptr, W: wptr <= 0
//   0x06 PKT_CNT  R: completed, non-aborted packets (mod 256)
module packet_tx_source #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = $clog2(N_PORTS),
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            writedata,
  input  logic                  write,
  input  logic                  chipselect,
  input  logic [7:0]            address,
  input  logic                  read,
  output logic [7:0]            readdata,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  output logic [IDX_WIDTH-1:0]  tx_tdest,
  input  logic                  tx_tready,
  output logic                  irq
);

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrDest   = 8'h01;
  localparam logic [7:0] AddrLen    = 8'h02;
  localparam logic [7:0] AddrDataLo = 8'h03;
  localparam logic [7:0] AddrDataHi = 8'h04;
  localparam logic [7:0] AddrWptr   = 8'h05;
  localparam logic [7:0] AddrPktCnt = 8'h06;

  localparam logic [7:0]           DepthB  = 8'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] WptrMax = PTR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [7:0]            readdata_q, readdata_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [IDX_WIDTH-1:0]  dest_reg_q, dest_reg_d;
  logic [7:0]            len_reg_q, len_reg_d;
  logic [7:0]            lo_q, lo_d;
  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [7:0]            pkt_cnt_q, pkt_cnt_d;
  logic [IDX_WIDTH-1:0]  dest_q, dest_d;
  logic [7:0]            len_q, len_d;
  logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic wr_en, rd_en, ctrl_wr, busy, idle, start_ok, mem_we, hs, last_by_cnt, beat_last;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign ctrl_wr = wr_en && (address == AddrCtrl);
  assign busy    = (state_q == StSend);
  assign idle    = ~busy;

  // A start with an out-of-range length is dropped without touching any flag.
  assign start_ok = ctrl_wr && writedata[0] && idle &&
                    (len_reg_q != 8'd0) && (len_reg_q <= DepthB);

  // Buffer is only writable while idle so an in-flight packet can't be corrupted.
  assign mem_we = wr_en && (address == AddrDataHi) && idle;

  assign hs          = tx_tvalid & tx_tready;
  assign last_by_cnt = (8'(rptr_q) == (len_q - 8'd1));
  // A pending abort turns the next beat into the last one, keeping framing legal.
  assign beat_last   = last_by_cnt | abort_pend_q;

  assign tx_tvalid = busy;
  assign tx_tlast  = busy & beat_last;
  assign tx_tdata  = busy ? mem_q[rptr_q] : '0;
  assign tx_tdest  = busy ? dest_q : '0;
  assign readdata  = readdata_q;
  assign irq       = done_q & irq_en_q;

  always_comb begin
    state_d      = state_q;
    readdata_d   = readdata_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    dest_reg_d   = dest_reg_q;
    len_reg_d    = len_reg_q;
    lo_d         = lo_q;
    wptr_d       = wptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    dest_d       = dest_q;
    len_d        = len_q;
    rptr_d       = rptr_q;

    // Register writes. Clear is applied first so a same-cycle set overrides it.
    if (ctrl_wr) begin
      irq_en_d = writedata[2];
      if (writedata[3]) begin
        done_d    = 1'b0;
        aborted_d = 1'b0;
      end
    end
    if (wr_en && idle) begin
      unique case (address)
        AddrDest:   dest_reg_d = writedata[IDX_WIDTH-1:0];
        AddrLen:    len_reg_d  = writedata;
        AddrDataHi: wptr_d     = (wptr_q == WptrMax) ? '0 : wptr_q + 1'b1;
        AddrWptr:   wptr_d     = '0;
        default:    ;
      endcase
    end
    if (wr_en && (address == AddrDataLo)) lo_d = writedata;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d      = StSend;
          dest_d       = dest_reg_q;
          len_d        = len_reg_q;
          rptr_d       = '0;
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
        end
      end
      StSend: begin
        if (ctrl_wr && writedata[1]) abort_pend_d = 1'b1;
        if (hs) begin
          rptr_d = rptr_q + 1'b1;
          if (beat_last) begin
            state_d      = StIdle;
            abort_pend_d = 1'b0;
            if (abort_pend_q) begin
              aborted_d = 1'b1;
            end else begin
              done_d    = 1'b1;
              pkt_cnt_d = pkt_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (rd_en) begin
      unique case (address)
        AddrCtrl:   readdata_d = {4'b0, irq_en_q, aborted_q, done_q, busy};
        AddrDest:   readdata_d = 8'(dest_reg_q);
        AddrLen:    readdata_d = len_reg_q;
        AddrWptr:   readdata_d = 8'(wptr_q);
        AddrPktCnt: readdata_d = pkt_cnt_q;
        default:    readdata_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      readdata_q   <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      dest_reg_q   <= '0;
      len_reg_q    <= '0;
      lo_q         <= '0;
      wptr_q       <= '0;
      pkt_cnt_q    <= '0;
      dest_q       <= '0;
      len_q        <= '0;
      rptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      readdata_q   <= readdata_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      dest_reg_q   <= dest_reg_d;
      len_reg_q    <= len_reg_d;
      lo_q         <= lo_d;
      wptr_q       <= wptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      dest_q       <= dest_d;
      len_q        <= len_d;
      rptr_q       <= rptr_d;
    end
  end

  // Buffer storage has no reset; its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= {writedata, lo_q};
  end

endmodule
